// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one synchronous RAM port between ch0 and ch1.
// Optional grant/stall counters are built when ARB_GRANT_STATS_EN is defined.
module ram_port_arbiter #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 8,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_di,
    input  logic [DWIDTH-1:0] ram_do,
`ifdef ARB_GRANT_STATS_EN
    output logic [31:0]       gnt_cnt0,
    output logic [31:0]       gnt_cnt1,
    output logic [31:0]       stall_cnt,
`endif
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    logic [1:0] state, state_nxt;
    logic       last, last_nxt;
    logic [7:0] burst_cnt, burst_nxt;
    logic       gnt0, gnt1, gnt_any, rd_acc;

    // Handshake: a request transfers in a cycle where reqN_valid and reqN_ready are both high;
    // ready is only ever raised for a valid requester, so every grant is an accept.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            OWN0: begin
                if (req1_valid && (burst_cnt == MAX_B || !req0_valid)) gnt1 = 1'b1;
                else if (req0_valid)                                   gnt0 = 1'b1;
            end
            OWN1: begin
                if (req0_valid && (burst_cnt == MAX_B || !req1_valid)) gnt0 = 1'b1;
                else if (req1_valid)                                   gnt1 = 1'b1;
            end
            default: begin
                if (last) begin
                    if (req0_valid)      gnt0 = 1'b1;
                    else if (req1_valid) gnt1 = 1'b1;
                end else begin
                    if (req1_valid)      gnt1 = 1'b1;
                    else if (req0_valid) gnt0 = 1'b1;
                end
            end
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign gnt_any = gnt0 | gnt1;

    always_comb begin
        state_nxt = IDLE;
        burst_nxt = 8'd0;
        last_nxt  = last;
        if (gnt_any) begin
            state_nxt = gnt1 ? OWN1 : OWN0;
            last_nxt  = gnt1;
            // Staying with the current owner extends the burst; any handover restarts it.
            if ((gnt0 && state == OWN0) || (gnt1 && state == OWN1))
                burst_nxt = (burst_cnt >= MAX_B) ? MAX_B : burst_cnt + 8'd1;
            else
                burst_nxt = 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign dbg_state  = state;

    assign ram_en   = gnt_any;
    assign ram_we   = gnt0 ? req0_we    : (gnt1 ? req1_we    : 1'b0);
    assign ram_addr = gnt0 ? req0_addr  : (gnt1 ? req1_addr  : '0);
    assign ram_di   = gnt0 ? req0_wdata : (gnt1 ? req1_wdata : '0);
    assign rd_acc   = gnt_any & ~ram_we;

    // Tag pipeline tracks which requester owns the RAM data arriving RAM_LATENCY cycles later.
    logic [RAM_LATENCY-1:0] tag_v, tag_ch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v  <= '0;
            tag_ch <= '0;
        end else begin
            tag_v[0]  <= rd_acc;
            tag_ch[0] <= gnt1;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
        end
    end

    assign rsp0_valid = tag_v[RAM_LATENCY-1] & ~tag_ch[RAM_LATENCY-1];
    assign rsp1_valid = tag_v[RAM_LATENCY-1] &  tag_ch[RAM_LATENCY-1];
    assign rsp0_data  = rsp0_valid ? ram_do : '0;
    assign rsp1_data  = rsp1_valid ? ram_do : '0;

`ifdef ARB_GRANT_STATS_EN
    logic stall;
    assign stall = (req0_valid & ~gnt0) | (req1_valid & ~gnt1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt0 && gnt_cnt0 != 32'hFFFF_FFFF)   gnt_cnt0  <= gnt_cnt0 + 32'd1;
            if (gnt1 && gnt_cnt1 != 32'hFFFF_FFFF)   gnt_cnt1  <= gnt_cnt1 + 32'd1;
            if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: dut_a (latency 1, burst 4) and dut_b (latency 2, burst 1) on behavioural RAMs.
module tb_ram_port_arbiter;

    typedef struct packed {
        logic [3:0]  gap;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } tx_t;

    typedef struct packed {
        logic        dut;
        logic        ch;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        b2b;
    } g_t;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
    } r_t;

    logic clk = 1'b0;
    logic rst;
    logic        req_valid [4];
    logic        req_ready [4];
    logic        req_we    [4];
    logic [7:0]  req_addr  [4];
    logic [31:0] req_wdata [4];
    logic        rsp_valid [4];
    logic [31:0] rsp_data  [4];
    logic        ram_en    [2];
    logic        ram_we    [2];
    logic [7:0]  ram_addr  [2];
    logic [31:0] ram_di    [2];
    logic [31:0] ram_do    [2];
    logic [1:0]  dbg_state [2];
`ifdef ARB_GRANT_STATS_EN
    logic [31:0] gnt_cnt0, gnt_cnt1, stall_cnt;
    logic [31:0] b_gnt_cnt0, b_gnt_cnt1, b_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc [2];
    int rsp_seen [4];
    tx_t tx_mem [4][16];
    int  tx_n   [4];
    g_t  gq[$];
    r_t  rq[$];
    int  rsp_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter #(.DWIDTH(32), .AWIDTH(8), .RAM_LATENCY(1), .MAX_BURST(4)) dut_a (
        .clk(clk), .reset(rst),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_we(req_we[0]),
        .req0_addr(req_addr[0]), .req0_wdata(req_wdata[0]),
        .rsp0_valid(rsp_valid[0]), .rsp0_data(rsp_data[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_we(req_we[1]),
        .req1_addr(req_addr[1]), .req1_wdata(req_wdata[1]),
        .rsp1_valid(rsp_valid[1]), .rsp1_data(rsp_data[1]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_di(ram_di[0]), .ram_do(ram_do[0]),
`ifdef ARB_GRANT_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .stall_cnt(stall_cnt),
`endif
        .dbg_state(dbg_state[0])
    );

    ram_port_arbiter #(.DWIDTH(32), .AWIDTH(8), .RAM_LATENCY(2), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset(rst),
        .req0_valid(req_valid[2]), .req0_ready(req_ready[2]), .req0_we(req_we[2]),
        .req0_addr(req_addr[2]), .req0_wdata(req_wdata[2]),
        .rsp0_valid(rsp_valid[2]), .rsp0_data(rsp_data[2]),
        .req1_valid(req_valid[3]), .req1_ready(req_ready[3]), .req1_we(req_we[3]),
        .req1_addr(req_addr[3]), .req1_wdata(req_wdata[3]),
        .rsp1_valid(rsp_valid[3]), .rsp1_data(rsp_data[3]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_di(ram_di[1]), .ram_do(ram_do[1]),
`ifdef ARB_GRANT_STATS_EN
        .gnt_cnt0(b_gnt_cnt0), .gnt_cnt1(b_gnt_cnt1), .stall_cnt(b_stall_cnt),
`endif
        .dbg_state(dbg_state[1])
    );

    // Behavioural RAMs: dut_a sees OUT_REG=0 (1 cycle), dut_b sees OUT_REG=1 (2 cycles).
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] do_a, do_b1, do_b2;

    always @(posedge clk) begin
        if (ram_en[0]) begin
            if (ram_we[0]) mem_a[ram_addr[0]] <= ram_di[0];
            do_a <= mem_a[ram_addr[0]];
        end
        if (ram_en[1]) begin
            if (ram_we[1]) mem_b[ram_addr[1]] <= ram_di[1];
            do_b1 <= mem_b[ram_addr[1]];
        end
        do_b2 <= do_b1;
    end

    assign ram_do[0] = do_a;
    assign ram_do[1] = do_b2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_tx(input int ch, input int gap, input logic we,
                          input logic [7:0] addr, input logic [31:0] data);
        tx_mem[ch][tx_n[ch]] = {4'(gap), we, addr, data};
        tx_n[ch]++;
    endtask

    task automatic add_gnt(input logic d, input logic ch, input logic we,
                           input logic [7:0] addr, input logic [31:0] data, input logic b2b);
        gq.push_back({d, ch, we, addr, data, b2b});
    endtask

    task automatic add_rsp(input logic [1:0] port, input logic [31:0] data);
        rq.push_back({port, data});
    endtask

    // Presents each transaction from a negedge and holds it until ready is seen high.
    task automatic drive(input int ch);
        for (int k = 0; k < tx_n[ch]; k++) begin
            logic acc;
            int   t;
            repeat (int'(tx_mem[ch][k].gap)) begin
                req_valid[ch] = 1'b0;
                @(negedge clk);
            end
            req_valid[ch] = 1'b1;
            req_we[ch]    = tx_mem[ch][k].we;
            req_addr[ch]  = tx_mem[ch][k].addr;
            req_wdata[ch] = tx_mem[ch][k].data;
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 100) begin
                #1 acc = req_ready[ch];
                @(negedge clk);
                t++;
            end
            check($sformatf("accept_ch%0d_tx%0d", ch, k), 64'(acc), 64'd1);
        end
        req_valid[ch] = 1'b0;
        req_we[ch]    = 1'b0;
        req_addr[ch]  = '0;
        req_wdata[ch] = '0;
        tx_n[ch]      = 0;
    endtask

    task automatic run_pair(input int a, input int b);
        fork
            drive(a);
            drive(b);
        join
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rsp_cyc_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((gq.size() != 0 || rq.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check({name, "_gnt_left"}, 64'(gq.size()), 64'd0);
        check({name, "_rsp_left"}, 64'(rq.size()), 64'd0);
    endtask

    // Monitor: samples mid-cycle, well clear of both clock edges.
    always begin
        @(negedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            if (ram_en[d]) begin
                logic ch;
                g_t   g;
                ch = req_ready[2*d+1];
                if (gq.size() == 0) begin
                    check($sformatf("gnt_unexpected_dut%0d", d), 64'd1, 64'd0);
                end else begin
                    g = gq.pop_front();
                    check($sformatf("gnt_dut%0d", d),
                          64'({1'(d), ch, ram_we[d], ram_addr[d], ram_di[d]}),
                          64'({g.dut, g.ch, g.we, g.addr, g.data}));
                    if (g.b2b) check($sformatf("gnt_b2b_dut%0d", d), 64'(cyc), 64'(last_cyc[d] + 1));
                end
                if (!ram_we[d]) rsp_cyc_q.push_back(cyc + ((d == 1) ? 2 : 1));
                last_cyc[d] = cyc;
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (rsp_valid[p]) begin
                r_t r;
                int c;
                rsp_seen[p]++;
                if (rq.size() == 0 || rsp_cyc_q.size() == 0) begin
                    check($sformatf("rsp_unexpected_port%0d", p), 64'd1, 64'd0);
                end else begin
                    r = rq.pop_front();
                    c = rsp_cyc_q.pop_front();
                    check("rsp", 64'({2'(p), rsp_data[p]}), 64'({r.port, r.data}));
                    check("rsp_latency", 64'(cyc), 64'(c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b1;
            req_we[i]    = 1'b1;
            req_addr[i]  = 8'hFF;
            req_wdata[i] = 32'hFFFF_FFFF;
            tx_n[i]      = 0;
            rsp_seen[i]  = 0;
        end
        last_cyc[0] = 0;
        last_cyc[1] = 0;
        rst = 1'b1;

        // Reset state with every requester asserting valid
        @(negedge clk);
        #3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_ready%0d", i), 64'(req_ready[i]), 64'd0);
            check($sformatf("reset_rsp_valid%0d", i), 64'(rsp_valid[i]), 64'd0);
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ram_en%0d", d), 64'(ram_en[d]), 64'd0);
            check($sformatf("reset_ram_we%0d", d), 64'(ram_we[d]), 64'd0);
            check($sformatf("reset_state%0d", d), 64'(dbg_state[d]), 64'd0);
        end
`ifdef ARB_GRANT_STATS_EN
        check("reset_gnt_cnt0", 64'(gnt_cnt0), 64'd0);
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        @(negedge clk);
        do_reset();

        // Single requester: write then read back on ch0
        add_tx(0, 0, 1'b1, 8'h10, 32'hA5A5_0001);
        add_tx(0, 0, 1'b0, 8'h10, 32'h0);
        add_gnt(1'b0, 1'b0, 1'b1, 8'h10, 32'hA5A5_0001, 1'b0);
        add_gnt(1'b0, 1'b0, 1'b0, 8'h10, 32'h0, 1'b1);
        add_rsp(2'd0, 32'hA5A5_0001);
        run_pair(0, 1);
        drain("single");

        // Burst lock: ch0 x4, ch1 x4, ch0 x4 with no idle cycles
        do_reset();
        for (int i = 0; i < 8; i++) add_tx(0, 0, 1'b1, 8'(8'h20 + i), 32'hC000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) add_tx(1, 0, 1'b1, 8'(8'h30 + i), 32'hD000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) add_gnt(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 32'hC000_0000 + 32'(i), i != 0);
        for (int i = 0; i < 4; i++) add_gnt(1'b0, 1'b1, 1'b1, 8'(8'h30 + i), 32'hD000_0000 + 32'(i), 1'b1);
        for (int i = 4; i < 8; i++) add_gnt(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 32'hC000_0000 + 32'(i), 1'b1);
        run_pair(0, 1);
        drain("burst");

        // Yield on idle: ch0 drops after 2 beats, returns once ch1 has had a full burst
        do_reset();
        add_tx(0, 0, 1'b1, 8'h40, 32'hE0);
        add_tx(0, 0, 1'b1, 8'h41, 32'hE1);
        add_tx(0, 1, 1'b1, 8'h42, 32'hE2);
        for (int i = 0; i < 4; i++) add_tx(1, 0, 1'b1, 8'(8'h50 + i), 32'hF0 + 32'(i));
        add_tx(1, 0, 1'b0, 8'h50, 32'h0);
        add_gnt(1'b0, 1'b0, 1'b1, 8'h40, 32'hE0, 1'b0);
        add_gnt(1'b0, 1'b0, 1'b1, 8'h41, 32'hE1, 1'b1);
        for (int i = 0; i < 4; i++) add_gnt(1'b0, 1'b1, 1'b1, 8'(8'h50 + i), 32'hF0 + 32'(i), 1'b1);
        add_gnt(1'b0, 1'b0, 1'b1, 8'h42, 32'hE2, 1'b1);
        add_gnt(1'b0, 1'b1, 1'b0, 8'h50, 32'h0, 1'b1);
        add_rsp(2'd1, 32'hF0);
        run_pair(0, 1);
        drain("yield");

        // Grant statistics: ch1 waits 3 cycles behind ch0
        do_reset();
        for (int i = 0; i < 3; i++) add_tx(0, 0, 1'b1, 8'(8'h60 + i), 32'h6000_0000 + 32'(i));
        add_tx(1, 0, 1'b1, 8'h70, 32'h7000_0000);
        for (int i = 0; i < 3; i++) add_gnt(1'b0, 1'b0, 1'b1, 8'(8'h60 + i), 32'h6000_0000 + 32'(i), i != 0);
        add_gnt(1'b0, 1'b1, 1'b1, 8'h70, 32'h7000_0000, 1'b1);
        run_pair(0, 1);
        drain("stats");
`ifdef ARB_GRANT_STATS_EN
        check("gnt_cnt0", 64'(gnt_cnt0), 64'd3);
        check("gnt_cnt1", 64'(gnt_cnt1), 64'd1);
        check("stall_cnt", 64'(stall_cnt), 64'd3);
`endif

        // Latency 2 with strict alternation (MAX_BURST=1)
        do_reset();
        add_tx(2, 0, 1'b1, 8'h01, 32'h11);
        add_tx(2, 0, 1'b0, 8'h01, 32'h0);
        add_tx(3, 0, 1'b1, 8'h02, 32'h22);
        add_tx(3, 0, 1'b0, 8'h02, 32'h0);
        add_gnt(1'b1, 1'b0, 1'b1, 8'h01, 32'h11, 1'b0);
        add_gnt(1'b1, 1'b1, 1'b1, 8'h02, 32'h22, 1'b1);
        add_gnt(1'b1, 1'b0, 1'b0, 8'h01, 32'h0, 1'b1);
        add_gnt(1'b1, 1'b1, 1'b0, 8'h02, 32'h0, 1'b1);
        add_rsp(2'd2, 32'h11);
        add_rsp(2'd3, 32'h22);
        run_pair(2, 3);
        drain("lat2");

        // Reset one cycle after a read accept drops the response
        do_reset();
        add_tx(2, 0, 1'b0, 8'h01, 32'h0);
        add_gnt(1'b1, 1'b0, 1'b0, 8'h01, 32'h0, 1'b0);
        run_pair(2, 3);
        snap = rsp_seen[2];
        do_reset();
        repeat (3) @(negedge clk);
        check("reset_drop_rsp", 64'(rsp_seen[2]), 64'(snap));
        check("reset_drop_gnt_left", 64'(gq.size()), 64'd0);
        add_tx(2, 0, 1'b1, 8'h03, 32'h33);
        add_tx(3, 0, 1'b1, 8'h04, 32'h44);
        add_gnt(1'b1, 1'b0, 1'b1, 8'h03, 32'h33, 1'b0);
        add_gnt(1'b1, 1'b1, 1'b1, 8'h04, 32'h44, 1'b1);
        run_pair(2, 3);
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one synchronous port of a ram_2port instance between two requesters (ch0, ch1), each with a valid/ready request channel.
- Arbitration: round-robin with a bounded burst lock.
- Read data is routed back to the issuing requester after the RAM's fixed read latency.
- Placement: between the RAM port and the client blocks, in the same clock domain as the RAM port.

Parameters:
DWIDTH, 32, data width; matches the RAM DWIDTH
AWIDTH, 8, address width; matches the RAM AWIDTH
RAM_LATENCY, 1, RAM read latency in cycles; 1 when OUT_REG=0, 2 when OUT_REG=1; only 1 and 2 are legal
MAX_BURST, 4, max consecutive grants to one requester while the other waits; range 1..255

Ports:
clk  in  1  clock; also drives the shared RAM port clock
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  ch0 request valid
req0_ready  out  1  ch0 request accepted this cycle
req0_we  in  1  ch0 write (1) / read (0)
req0_addr  in  AWIDTH  ch0 address
req0_wdata  in  DWIDTH  ch0 write data
rsp0_valid  out  1  ch0 read data valid
rsp0_data  out  DWIDTH  ch0 read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_data  same as ch0, for ch1
ram_en  out  1  to RAM en
ram_we  out  1  to RAM we
ram_addr  out  AWIDTH  to RAM addr
ram_di  out  DWIDTH  to RAM di
ram_do  in  DWIDTH  from RAM do

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, last=1, burst_cnt=0, tag pipeline cleared.
  - All ready, rsp_valid and ram_en/ram_we outputs are 0 while reset is high.
- Grant logic:
  - Combinational from state and the two valids; at most one grant per cycle.
  - reqN_ready = grantN. Accept = reqN_valid & grantN.
- Request drive: ram_en = accept. ram_we / ram_addr / ram_di are muxed from the granted channel; all zero when there is no grant.
- FSM states: IDLE, OWN0, OWN1. burst_cnt is 8 bits.
  - IDLE: grant the requester other than `last` if it is valid, else the valid one. Next state OWNg, burst_cnt=1.
  - OWNi, other requester j valid, and (burst_cnt==MAX_BURST or !valid_i): grant j, next state OWNj, burst_cnt=1.
  - OWNi, valid_i, and (!valid_j or burst_cnt<MAX_BURST): grant i, burst_cnt=min(burst_cnt+1, MAX_BURST).
  - No valid at all: no grant, next state IDLE, burst_cnt=0. `last` holds the most recently granted channel.
- Request stability: requests are not retracted. A requester holds valid and its fields stable until accepted; the block relies on this and does not check it.
- Read responses:
  - Accepted reads push {valid, ch} into a RAM_LATENCY-deep tag shift register. Writes push valid=0.
  - rspN_valid = tail.valid & (tail.ch==N).
  - rspN_data = ram_do when rspN_valid, else 0.
  - A read accepted in cycle N gives rsp_valid in cycle N+RAM_LATENCY.
  - There is no response backpressure; full throughput is one access per cycle.
- Write responses: writes produce no response. Read data for a same-address write-then-read follows the RAM's RW_MODE; the arbiter does not reorder.
- Back-to-back: grants may alternate every cycle with no bubble (MAX_BURST=1 gives strict alternation).
- Reset mid-operation: in-flight tags are cleared and pending read responses are dropped. Requesters must reissue them.

Optional Feature:
Macro ARB_GRANT_STATS_EN.
- Defined: adds output ports gnt_cnt0 and gnt_cnt1 (32 bits each) and output stall_cnt (32 bits). All three are cleared on reset.
  - gnt_cntN increments on each accept for chN.
  - stall_cnt increments each cycle in which some reqN_valid is high and reqN_ready is low.
  - All three saturate at 0xFFFFFFFF.
- Undefined: the ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Single requester: ch0 writes 0xA5A5_0001 to addr 0x10, then reads 0x10 (RAM_LATENCY=1) -> ram_en high both cycles; rsp0_valid high exactly 1 cycle after the read accept, with rsp0_data=0xA5A5_0001; rsp1_valid stays 0.
- Burst lock: MAX_BURST=4, both requesters valid continuously from reset -> grant order 1? no: `last` resets to 1, so ch0 wins first; order is ch0 x4, ch1 x4, ch0 x4, with no idle cycles.
- Yield on idle: ch0 owns and drops valid after 2 beats while ch1 is valid -> ch1 is granted in the next cycle; burst_cnt restarts at 1.
- Latency 2: RAM_LATENCY=2 with OUT_REG=1 RAM; interleaved reads ch0@0x01 and ch1@0x02 containing 0x11 and 0x22 -> rsp0 returns 0x11 two cycles after its accept and rsp1 returns 0x22 the following cycle.
- Reset mid-flight: assert reset one cycle after a read accept -> rsp0_valid is never asserted for that read; after reset, ch0 is granted first.
- Stats (ARB_GRANT_STATS_EN defined): 3 ch0 writes while ch1 waits 3 cycles, then 1 ch1 write -> gnt_cnt0=3, gnt_cnt1=1, stall_cnt=3.
